// File: rtl/tone_sampler.sv
// tone_sampler: decimates a continuous sample stream to f_sample, applies a
// Q1.15 gain with rounding and saturation, and buffers results in a 2-entry FIFO.
module tone_sampler #(
  parameter int unsigned f_sample   = 48_000,
  parameter int unsigned f_clock    = 100_000_000,
  parameter int unsigned DATA_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  data_in_valid_i,
  input  logic [DATA_WIDTH-1:0] data_in_data_i,
  output logic                  data_in_ready_o,
  input  logic                  gain_valid_i,
  input  logic [15:0]           gain_data_i,
  output logic                  gain_ready_o,
  output logic                  data_out_valid_o,
  output logic [DATA_WIDTH-1:0] data_out_data_o,
  input  logic                  data_out_ready_i,
  output logic [15:0]           overrun_count_o
);

  localparam int unsigned AccW  = $clog2(f_clock + f_sample + 1);
  localparam int unsigned GainW = 16;
  localparam int unsigned PW    = DATA_WIDTH + 17;
  localparam logic [GainW-1:0] UnityGain = 16'h8000;

  // Rate accumulator, input hold, gain and pipeline registers
  logic [AccW-1:0]                acc_q, acc_d, acc_sum;
  logic                           tick;
  logic [DATA_WIDTH-1:0]          hold_q;
  logic [GainW-1:0]               pend_gain_q, active_gain_q, active_gain_d;
  logic [DATA_WIDTH-1:0]          x_q;
  logic [GainW-1:0]               g_q;
  logic                           s0_v_q, s1_v_q;
  logic signed [PW-1:0]           p_q, p_d, x_ext, g_ext;
  logic signed [PW-1:0]           rnd, shifted;
  logic [DATA_WIDTH-1:0]          y;

  // FIFO registers
  logic [DATA_WIDTH-1:0]          head_q, head_d, tail_q, tail_d;
  logic [1:0]                     cnt_q, cnt_d;
  logic                           valid_q, valid_d;
  logic [15:0]                    ovr_q, ovr_d;
  logic                           push, pop;

  // Both slave inputs accept every beat
  assign data_in_ready_o = 1'b1;
  assign gain_ready_o    = 1'b1;

  // Fractional rate generator: adds f_sample per cycle, wraps at f_clock
  always_comb begin
    acc_sum = acc_q + AccW'(f_sample);
    tick    = (acc_sum >= AccW'(f_clock));
    acc_d   = tick ? (acc_sum - AccW'(f_clock)) : acc_sum;
    active_gain_d = tick ? pend_gain_q : active_gain_q;
  end

  // Multiply and round/saturate datapath
  always_comb begin
    x_ext   = PW'($signed(x_q));
    g_ext   = PW'($signed({1'b0, g_q}));
    p_d     = x_ext * g_ext;
    rnd     = p_q + $signed(PW'(16384));
    shifted = rnd >>> 15;
    if ((&shifted[PW-1:DATA_WIDTH-1]) || !(|shifted[PW-1:DATA_WIDTH-1])) begin
      y = shifted[DATA_WIDTH-1:0];
    end else if (shifted[PW-1]) begin
      y = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      y = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
  end

  // Front-end state: accumulator, held sample, gains, S0/S1 stages
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q         <= '0;
      hold_q        <= '0;
      pend_gain_q   <= UnityGain;
      active_gain_q <= UnityGain;
      x_q           <= '0;
      g_q           <= UnityGain;
      s0_v_q        <= 1'b0;
      p_q           <= '0;
      s1_v_q        <= 1'b0;
    end else begin
      acc_q         <= acc_d;
      active_gain_q <= active_gain_d;
      if (data_in_valid_i) hold_q <= data_in_data_i;
      if (gain_valid_i) pend_gain_q <= gain_data_i;
      s0_v_q <= tick;
      if (tick) begin
        x_q <= hold_q;
        g_q <= active_gain_d;
      end
      s1_v_q <= s0_v_q;
      if (s0_v_q) p_q <= p_d;
    end
  end

  // FIFO next-state: head register plus one spare entry, drop on full
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    ovr_d  = ovr_q;
    push   = s1_v_q;
    pop    = valid_q && data_out_ready_i;
    case (cnt_q)
      2'd0: begin
        if (push) begin
          head_d = y;
          cnt_d  = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = y;
        end else if (push) begin
          tail_d = y;
          cnt_d  = 2'd2;
        end else if (pop) begin
          cnt_d  = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          head_d = tail_q;
          if (push) tail_d = y;
          else      cnt_d  = 2'd1;
        end else if (push && (ovr_q != 16'hFFFF)) begin
          ovr_d = ovr_q + 16'd1;
        end
      end
    endcase
    valid_d = (cnt_d != 2'd0);
  end

  // FIFO and overrun counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= 2'd0;
      valid_q <= 1'b0;
      ovr_q   <= 16'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_out_valid_o = valid_q;
  assign data_out_data_o  = head_q;
  assign overrun_count_o  = ovr_q;

endmodule

// File: tb/tb_tone_sampler.sv
// Bench for tone_sampler: directed steps plus random traffic against a
// queue-based reference model derived from the sampling rules.
module tb_tone_sampler;

  localparam int unsigned FS = 30;
  localparam int unsigned FC = 100;
  localparam int unsigned DW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          din_v;
  logic [DW-1:0] din;
  logic          din_rdy;
  logic          gv;
  logic [15:0]   g;
  logic          g_rdy;
  logic          dout_valid;
  logic [DW-1:0] dout_data;
  logic          rdy;
  logic [15:0]   ovr;

  tone_sampler #(.f_sample(FS), .f_clock(FC), .DATA_WIDTH(DW)) dut (
    .clk              (clk),
    .reset            (rst),
    .data_in_valid_i  (din_v),
    .data_in_data_i   (din),
    .data_in_ready_o  (din_rdy),
    .gain_valid_i     (gv),
    .gain_data_i      (g),
    .gain_ready_o     (g_rdy),
    .data_out_valid_o (dout_valid),
    .data_out_data_o  (dout_data),
    .data_out_ready_i (rdy),
    .overrun_count_o  (ovr)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  longint        cyc;
  logic [DW-1:0] mq[$];
  longint        pd_due[$];
  logic [DW-1:0] pd_val[$];
  logic [DW-1:0] m_hold;
  logic [15:0]   m_gain;
  logic [15:0]   m_ovr;
  int            m_pushes;

  logic          obs_valid;
  logic [DW-1:0] obs_data;
  logic [15:0]   obs_ovr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  function automatic bit is_tick(input longint c);
    return ((c + 1) * FS) / FC != (c * FS) / FC;
  endfunction

  function automatic logic [DW-1:0] scale(input logic [DW-1:0] x, input logic [15:0] gg);
    longint xs, p, yy;
    xs = x[DW-1] ? (longint'(x) - (longint'(1) << DW)) : longint'(x);
    p  = xs * longint'(gg) + 16384;
    yy = p >>> 15;
    if (yy > 8388607)  yy = 8388607;
    if (yy < -8388608) yy = -8388608;
    return DW'(yy);
  endfunction

  task automatic model_reset();
    mq.delete();
    pd_due.delete();
    pd_val.delete();
    m_hold = '0;
    m_gain = 16'h8000;
    m_ovr  = 16'd0;
  endtask

  // Model effect of the clock edge that ends cycle cyc
  task automatic model_edge();
    logic [DW-1:0] v;
    if (mq.size() > 0 && rdy) void'(mq.pop_front());
    if (pd_due.size() > 0 && pd_due[0] == cyc) begin
      void'(pd_due.pop_front());
      v = pd_val.pop_front();
      m_pushes++;
      if (mq.size() < 2) mq.push_back(v);
      else if (m_ovr != 16'hFFFF) m_ovr = m_ovr + 16'd1;
    end
    if (is_tick(cyc)) begin
      pd_due.push_back(cyc + 2);
      pd_val.push_back(scale(m_hold, m_gain));
    end
    if (gv) m_gain = g;
    if (din_v) m_hold = din;
    cyc++;
  endtask

  // One clock cycle: sample outputs mid-cycle, compare with model, advance
  task automatic step();
    @(negedge clk);
    obs_valid = dout_valid;
    obs_data  = dout_data;
    obs_ovr   = ovr;
    check("valid", {31'd0, obs_valid}, {31'd0, (mq.size() > 0)});
    if (mq.size() > 0) check("data", {8'd0, obs_data}, {8'd0, mq[0]});
    check("overrun", {16'd0, obs_ovr}, {16'd0, m_ovr});
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic ramp(input int n);
    for (int i = 0; i < n; i++) begin
      din = din + 24'd1;
      step();
    end
  endtask

  task automatic wait_valid(input string tag, input logic [DW-1:0] exp);
    bit found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      found = obs_valid;
    end
    check({tag, "_seen"}, {31'd0, found}, 32'd1);
    check(tag, {8'd0, obs_data}, {8'd0, exp});
  endtask

  task automatic do_reset(input logic v_after, input logic [DW-1:0] d_after);
    #2 rst = 1'b0;
    #1;
    check("rst_valid", {31'd0, dout_valid}, 32'd0);
    check("rst_ovr", {16'd0, ovr}, 32'd0);
    check("rst_data", {8'd0, dout_data}, 32'd0);
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    din_v = v_after;
    din   = d_after;
    gv    = 1'b0;
    rdy   = 1'b1;
    #1 rst = 1'b1;
    cyc = 0;
  endtask

  initial begin
    int p0, pops, bad_sp;
    longint last_v;
    logic [DW-1:0] e0, e1;
    rst = 1'b0; din_v = 1'b0; din = '0; gv = 1'b0; g = '0; rdy = 1'b1;
    m_pushes = 0;
    model_reset();
    #3;
    check("reset_valid", {31'd0, dout_valid}, 32'd0);
    check("reset_data", {8'd0, dout_data}, 32'd0);
    check("reset_ovr", {16'd0, ovr}, 32'd0);
    check("din_ready", {31'd0, din_rdy}, 32'd1);
    check("gain_ready", {31'd0, g_rdy}, 32'd1);
    @(posedge clk); #1;
    din_v = 1'b1; din = 24'h123456;
    #1 rst = 1'b1;
    cyc = 0;

    // Unity gain and latency from tick to valid
    run(10);
    for (int i = 0; i < 10 && !is_tick(cyc); i++) step();
    step();
    step(); check("lat_t1", {31'd0, obs_valid}, 32'd0);
    step(); check("lat_t2", {31'd0, obs_valid}, 32'd0);
    step(); check("lat_t3", {31'd0, obs_valid}, 32'd1);
    check("unity_pos", {8'd0, obs_data}, 32'h123456);
    din = 24'hF00001; run(10);
    wait_valid("unity_neg", 24'hF00001);

    // Gain write coinciding with a tick
    din = 24'd1000; run(10);
    for (int i = 0; i < 10 && !is_tick(cyc); i++) step();
    gv = 1'b1; g = 16'h4000;
    step();
    gv = 1'b0;
    wait_valid("gain_old", 24'd1000);
    wait_valid("gain_new", 24'd500);

    // Rounding at half gain
    din = 24'd3; run(12);
    wait_valid("round_pos", 24'd2);
    din = 24'hFFFFFD; run(10);
    wait_valid("round_neg", 24'hFFFFFF);

    // Saturation at max gain
    gv = 1'b1; g = 16'hFFFF; step(); gv = 1'b0;
    din = 24'h7FFFFF; run(12);
    wait_valid("sat_pos", 24'h7FFFFF);
    din = 24'h800000; run(10);
    wait_valid("sat_neg", 24'h800000);

    // Backpressure across 5 ticks
    gv = 1'b1; g = 16'h8000; step(); gv = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mq.size() == 0 && pd_due.size() == 0) break;
      step();
    end
    rdy = 1'b0;
    p0 = m_pushes;
    for (int i = 0; i < 40; i++) begin
      if (m_pushes - p0 >= 5) break;
      din = din + 24'd1;
      step();
    end
    check("bp_ovr", {16'd0, ovr}, 32'd3);
    check("bp_valid", {31'd0, dout_valid}, 32'd1);
    e0 = mq[0];
    e1 = mq[1];
    rdy = 1'b1;
    step(); check("bp_first", {8'd0, obs_data}, {8'd0, e0});
    step(); check("bp_second", {8'd0, obs_data}, {8'd0, e1});
    ramp(20);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      din_v = ($urandom % 4) != 0;
      din   = DW'($urandom);
      gv    = ($urandom % 16) == 0;
      g     = 16'($urandom);
      rdy   = ($urandom % 3) != 0;
      step();
    end

    // Async reset with a full FIFO and a non-unity pending gain
    din_v = 1'b1; din = 24'h55AA55;
    gv = 1'b1; g = 16'h1234; step(); gv = 1'b0;
    rdy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (mq.size() == 2 && m_ovr != 0) break;
      step();
    end
    check("pre_rst_full", {31'd0, dout_valid}, 32'd1);
    do_reset(1'b1, 24'd777);
    wait_valid("post_rst_hold", 24'd777);

    // Long-run rate and tick spacing
    pops = 0; bad_sp = 0; last_v = -1;
    for (int i = 0; i < 1000; i++) begin
      din = din + 24'd1;
      step();
      if (obs_valid) begin
        pops++;
        if (last_v >= 0 && (cyc - 1 - last_v < 3 || cyc - 1 - last_v > 4)) bad_sp++;
        last_v = cyc - 1;
      end
    end
    check("rate", pops, 32'd300);
    check("spacing", bad_sp, 32'd0);

    // Reset with no input afterwards: output reads zero
    do_reset(1'b0, 24'd0);
    wait_valid("post_rst_nohold", 24'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
